// File: rtl/vend_pkg.sv
// Shared vending-path definitions: FSM state encoding and coin denominations in 50-units.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    P100,
    G100,
    P50,
    G50,
    DONE,
    FAULT
  } vend_state_e;

  localparam int unsigned COIN_50  = 1;
  localparam int unsigned COIN_100 = 2;

endpackage

// File: rtl/coin_pulse_timer.sv
// Down-counter timing one coin: PULSE_CYC active cycles, then GAP_CYC gap cycles.
// pulse_end/gap_end flag the last cycle of each phase.
module coin_pulse_timer #(
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic pulse_end,
  output logic gap_end
);

  localparam int unsigned MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {T_IDLE, T_PULSE, T_GAP} phase_e;

  phase_e        phase;
  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= T_IDLE;
      cnt   <= '0;
    end else if (start) begin
      phase <= T_PULSE;
      cnt   <= TW'(PULSE_CYC - 1);
    end else begin
      case (phase)
        T_PULSE: begin
          if (cnt == '0) begin
            phase <= T_GAP;
            cnt   <= TW'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        T_GAP: begin
          if (cnt == '0) phase <= T_IDLE;
          else           cnt   <= cnt - TW'(1);
        end
        default: phase <= T_IDLE;
      endcase
    end
  end

  assign pulse_end = (phase == T_PULSE) && (cnt == '0);
  assign gap_end   = (phase == T_GAP)   && (cnt == '0);

endmodule

// File: rtl/coin_change_dispenser.sv
// Greedy refund payout: 100-coins first, then 50-coins, bounded by on-board inventory.
// Coins are driven to the hopper as timed pulses sequenced around coin_pulse_timer.
module coin_change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W     = 4,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             load,
  input  logic [CNT_W-1:0] load100,
  input  logic [CNT_W-1:0] load50,
  output logic             coin100,
  output logic             coin50,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] inv100,
  output logic [CNT_W-1:0] inv50
);

  localparam int unsigned W = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

  vend_state_e      state;
  logic [AMT_W-1:0] amount_q;
  logic [AMT_W-1:0] pend100;
  logic [AMT_W:0]   pend50;

  logic [W-1:0] half, n100_c, n50_c;
  logic         short_c;
  logic         start;
  logic         pulse_end, gap_end;

  // Plan for CHECK, and the timer kick for every coin that is about to go high.
  always_comb begin
    half    = W'(amount_q >> 1);
    n100_c  = (half < W'(inv100)) ? half : W'(inv100);
    n50_c   = W'(amount_q) - W'(COIN_100) * n100_c;
    short_c = n50_c > W'(inv50);
    start   = 1'b0;
    case (state)
      CHECK: start = !short_c && ((n100_c != '0) || (n50_c != '0));
      G100:  start = gap_end && ((pend100 != '0) || (pend50 != '0));
      G50:   start = gap_end && (pend50 != '0);
      default: start = 1'b0;
    endcase
  end

  coin_pulse_timer #(
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pulse_end (pulse_end),
    .gap_end   (gap_end)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      amount_q <= '0;
      pend100  <= '0;
      pend50   <= '0;
      coin100  <= 1'b0;
      coin50   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      inv100   <= '0;
      inv50    <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            inv100 <= load100;
            inv50  <= load50;
          end else if (req) begin
            amount_q <= amount;
            state    <= CHECK;
            busy     <= 1'b1;
          end
        end
        CHECK: begin
          if (short_c) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            pend100 <= n100_c[AMT_W-1:0];
            pend50  <= n50_c[AMT_W:0];
            if (n100_c != '0) begin
              state   <= P100;
              coin100 <= 1'b1;
              inv100  <= inv100 - CNT_W'(1);
            end else if (n50_c != '0) begin
              state  <= P50;
              coin50 <= 1'b1;
              inv50  <= inv50 - CNT_W'(1);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        P100: begin
          if (pulse_end) begin
            coin100 <= 1'b0;
            pend100 <= pend100 - AMT_W'(1);
            state   <= G100;
          end
        end
        G100: begin
          if (gap_end) begin
            if (pend100 != '0) begin
              state   <= P100;
              coin100 <= 1'b1;
              inv100  <= inv100 - CNT_W'(1);
            end else if (pend50 != '0) begin
              state  <= P50;
              coin50 <= 1'b1;
              inv50  <= inv50 - CNT_W'(1);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        P50: begin
          if (pulse_end) begin
            coin50 <= 1'b0;
            pend50 <= pend50 - (AMT_W+1)'(1);
            state  <= G50;
          end
        end
        G50: begin
          if (gap_end) begin
            if (pend50 != '0) begin
              state  <= P50;
              coin50 <= 1'b1;
              inv50  <= inv50 - CNT_W'(1);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE, FAULT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
